// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared constants for the register-file write arbiter.
package regfile_write_arbiter_pkg;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 6;
    localparam int REG_COUNT = 32;
    localparam int ERR_W     = 8;
    localparam int REQ_ALU   = 0;
    localparam int REQ_LOAD  = 1;
    localparam int ZERO_REG  = 0;
endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the pointer favours the loser of the last grant.
module rr_arb2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_ptr;

    always_comb begin
        o_gnt = '0;
        if (rst_n) begin
            o_gnt[REQ_ALU]  = i_req[REQ_ALU] & (~i_req[REQ_LOAD] | ~r_ptr);
            o_gnt[REQ_LOAD] = i_req[REQ_LOAD] & (~i_req[REQ_ALU] | r_ptr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 1'b0;
        else if (|o_gnt)
            r_ptr <= o_gnt[REQ_ALU];
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU and load writeback,
// squashing $zero/illegal writes and flagging read hazards for decode.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W    = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W    = regfile_write_arbiter_pkg::ADDR_W,
    parameter int REG_COUNT = regfile_write_arbiter_pkg::REG_COUNT,
    parameter int ERR_W     = regfile_write_arbiter_pkg::ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0Valid,
    input  logic [ADDR_W-1:0] req0Addr,
    input  logic [DATA_W-1:0] req0Data,
    output logic              req0Ready,
    input  logic              req1Valid,
    input  logic [ADDR_W-1:0] req1Addr,
    input  logic [DATA_W-1:0] req1Data,
    output logic              req1Ready,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic              stall,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0] writeData,
    output logic [ERR_W-1:0]  errCnt
);
    localparam logic [ADDR_W:0] REG_LIM = (ADDR_W + 1)'(REG_COUNT);

    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_illegal;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ERR_W-1:0]  r_err;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req ({req1Valid, req0Valid}),
        .o_gnt (w_gnt)
    );

    assign req0Ready = w_gnt[REQ_ALU];
    assign req1Ready = w_gnt[REQ_LOAD];
    assign w_any     = |w_gnt;
    assign w_addr    = w_gnt[REQ_LOAD] ? req1Addr : req0Addr;
    assign w_data    = w_gnt[REQ_LOAD] ? req1Data : req0Data;
    assign w_illegal = {1'b0, w_addr} >= REG_LIM;
    assign w_we      = w_any & ~w_illegal & (w_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_err  <= '0;
        end else begin
            r_we <= w_we;
            if (w_we) begin
                r_addr <= w_addr;
                r_data <= w_data;
            end
            if (w_any & w_illegal & ~&r_err)
                r_err <= r_err + 1'b1;
        end
    end

    // The register file returns the old value on a same-edge read, so any pending write must stall.
    function automatic logic hit(input logic [ADDR_W-1:0] a);
        return (a != ADDR_W'(ZERO_REG)) &&
               ((r_we && a == r_addr) || (req0Valid && a == req0Addr) || (req1Valid && a == req1Addr));
    endfunction

    assign stall         = hit(rdAddr1) | hit(rdAddr2);
    assign regWrite      = r_we;
    assign writeRegister = r_addr;
    assign writeData     = r_data;
    assign errCnt        = r_err;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0Valid = 1'b0, req1Valid = 1'b0;
    logic [5:0]  req0Addr = '0, req1Addr = '0, rdAddr1 = '0, rdAddr2 = '0;
    logic [31:0] req0Data = '0, req1Data = '0;
    logic        req0Ready, req1Ready, stall, regWrite;
    logic [5:0]  writeRegister;
    logic [31:0] writeData;
    logic [7:0]  errCnt;

    int n_checks = 0;
    int n_fail = 0;

    bit          m_we;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    int          m_err;
    int          m_ptr;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Data(req0Data), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Data(req1Data), .req1Ready(req1Ready),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .stall(stall),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData), .errCnt(errCnt)
    );

    always #5 clk = ~clk;

    function automatic int winner();
        if (req0Valid && req1Valid) return m_ptr;
        if (req0Valid) return 0;
        if (req1Valid) return 1;
        return -1;
    endfunction

    function automatic bit hazard(input logic [5:0] a);
        return a != 0 && ((m_we && a == m_addr) || (req0Valid && a == req0Addr) || (req1Valid && a == req1Addr));
    endfunction

    task automatic model_reset();
        m_we = 0; m_addr = 0; m_data = 0; m_err = 0; m_ptr = 0;
    endtask

    task automatic tick();
        int w;
        logic [5:0] a;
        @(posedge clk);
        if (rst_n) begin
            w = winner();
            if (w < 0) m_we = 0;
            else begin
                a = (w == 1) ? req1Addr : req0Addr;
                m_we = (a != 0) && (a < 32);
                if (m_we) begin
                    m_addr = a;
                    m_data = (w == 1) ? req1Data : req0Data;
                end
                if (a >= 32 && m_err < 255) m_err++;
                m_ptr = 1 - w;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; req0Valid = 0; req1Valid = 0;
        #1;
        model_reset();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0Valid = 1; req1Valid = 1; req0Addr = 3; req1Addr = 4;
        #2;
        n_checks += 6;
        if (regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regWrite got %b want 0", regWrite); end
        if (writeRegister !== 6'd0) begin n_fail++; $display("FAIL reset_writeRegister got %0d want 0", writeRegister); end
        if (writeData !== 32'd0) begin n_fail++; $display("FAIL reset_writeData got %h want 0", writeData); end
        if (errCnt !== 8'd0) begin n_fail++; $display("FAIL reset_errCnt got %0d want 0", errCnt); end
        if (req0Ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0Ready got %b want 0", req0Ready); end
        if (req1Ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1Ready got %b want 0", req1Ready); end
        req0Valid = 0; req1Valid = 0;
        model_reset();
        tick();
        rst_n = 1;
    endtask

    task automatic test_single();
        req0Valid = 1; req0Addr = 5; req0Data = 32'hDEADBEEF; req1Valid = 0;
        #2;
        n_checks++;
        if (req0Ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", req0Ready); end
        tick();
        req0Valid = 0;
        #2;
        n_checks += 3;
        if (regWrite !== 1'b1) begin n_fail++; $display("FAIL single_regWrite got %b want 1", regWrite); end
        if (writeRegister !== 6'd5) begin n_fail++; $display("FAIL single_writeRegister got %0d want 5", writeRegister); end
        if (writeData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_writeData got %h want deadbeef", writeData); end
        tick();
        #2;
        n_checks++;
        if (regWrite !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", regWrite); end
    endtask

    task automatic test_alternate();
        logic [5:0] want;
        do_reset();
        req0Valid = 1; req0Addr = 3; req1Valid = 1; req1Addr = 4;
        for (int i = 0; i < 8; i++) begin
            req0Data = $urandom; req1Data = $urandom;
            #2;
            n_checks += 2;
            if (req0Ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL alt_req0Ready cycle %0d got %b want %b", i, req0Ready, i % 2 == 0); end
            if (req1Ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_req1Ready cycle %0d got %b want %b", i, req1Ready, i % 2 == 1); end
            if (i > 0) begin
                want = (i % 2 == 1) ? 6'd3 : 6'd4;
                n_checks += 2;
                if (regWrite !== 1'b1) begin n_fail++; $display("FAIL alt_regWrite cycle %0d got %b want 1", i, regWrite); end
                if (writeRegister !== want) begin n_fail++; $display("FAIL alt_writeRegister cycle %0d got %0d want %0d", i, writeRegister, want); end
            end
            tick();
        end
        req0Valid = 0; req1Valid = 0;
        tick();
    endtask

    task automatic test_squash();
        do_reset();
        req1Valid = 1; req1Addr = 0; req1Data = 32'h1234;
        #2;
        n_checks++;
        if (req1Ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", req1Ready); end
        tick();
        req1Addr = 40;
        #2;
        n_checks += 3;
        if (regWrite !== 1'b0) begin n_fail++; $display("FAIL zero_regWrite got %b want 0", regWrite); end
        if (errCnt !== 8'd0) begin n_fail++; $display("FAIL zero_errCnt got %0d want 0", errCnt); end
        if (req1Ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %b want 1", req1Ready); end
        tick();
        req1Valid = 0;
        #2;
        n_checks += 2;
        if (regWrite !== 1'b0) begin n_fail++; $display("FAIL illegal_regWrite got %b want 0", regWrite); end
        if (errCnt !== 8'd1) begin n_fail++; $display("FAIL illegal_errCnt got %0d want 1", errCnt); end
        for (int i = 0; i < 300; i++) begin
            req0Valid = 1; req0Addr = 6'($urandom_range(32, 63));
            tick();
        end
        req0Valid = 0;
        #2;
        n_checks++;
        if (errCnt !== 8'd255) begin n_fail++; $display("FAIL errCnt_saturate got %0d want 255", errCnt); end
        tick();
    endtask

    task automatic test_hazard();
        req0Valid = 1; req0Addr = 7; req0Data = 32'h77; req1Valid = 0; rdAddr1 = 7; rdAddr2 = 0;
        #2;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL hazard_request got %b want 1", stall); end
        tick();
        req0Valid = 0;
        #2;
        n_checks += 2;
        if (regWrite !== 1'b1) begin n_fail++; $display("FAIL hazard_regWrite got %b want 1", regWrite); end
        if (stall !== 1'b1) begin n_fail++; $display("FAIL hazard_output got %b want 1", stall); end
        tick();
        #2;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL hazard_clear got %b want 0", stall); end
        rdAddr1 = 0; rdAddr2 = 0; req0Valid = 1; req0Addr = 0; req1Valid = 1; req1Addr = 9;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL hazard_zero got %b want 0", stall); end
        tick();
        req0Valid = 0; req1Valid = 0;
        tick();
    endtask

    task automatic test_async_reset();
        req0Valid = 1; req0Addr = 12; req0Data = 32'hCAFE0012;
        tick();
        req0Valid = 0;
        #2;
        n_checks++;
        if (regWrite !== 1'b1) begin n_fail++; $display("FAIL async_pre got %b want 1", regWrite); end
        rst_n = 0;
        #1;
        n_checks += 2;
        if (regWrite !== 1'b0) begin n_fail++; $display("FAIL async_regWrite got %b want 0", regWrite); end
        if (writeRegister !== 6'd0) begin n_fail++; $display("FAIL async_writeRegister got %0d want 0", writeRegister); end
        model_reset();
        tick();
        rst_n = 1;
        req0Valid = 1; req0Addr = 1; req1Valid = 1; req1Addr = 2;
        #2;
        n_checks += 2;
        if (req0Ready !== 1'b1) begin n_fail++; $display("FAIL async_first_req0 got %b want 1", req0Ready); end
        if (req1Ready !== 1'b0) begin n_fail++; $display("FAIL async_first_req1 got %b want 0", req1Ready); end
        tick();
        req0Valid = 0; req1Valid = 0;
        tick();
    endtask

    task automatic test_random();
        bit hold0 = 0, hold1 = 0;
        int w;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (!hold0) begin
                req0Valid = 1'($urandom_range(0, 1)); req0Addr = 6'($urandom_range(0, 40)); req0Data = $urandom;
            end
            if (!hold1) begin
                req1Valid = 1'($urandom_range(0, 1)); req1Addr = 6'($urandom_range(0, 40)); req1Data = $urandom;
            end
            rdAddr1 = 6'($urandom_range(0, 15)); rdAddr2 = 6'($urandom_range(0, 15));
            #2;
            w = winner();
            n_checks += 5;
            if (req0Ready !== (w == 0)) begin n_fail++; $display("FAIL rand_req0Ready cycle %0d got %b want %b", i, req0Ready, w == 0); end
            if (req1Ready !== (w == 1)) begin n_fail++; $display("FAIL rand_req1Ready cycle %0d got %b want %b", i, req1Ready, w == 1); end
            if (stall !== (hazard(rdAddr1) || hazard(rdAddr2))) begin n_fail++; $display("FAIL rand_stall cycle %0d got %b want %b", i, stall, hazard(rdAddr1) || hazard(rdAddr2)); end
            if (regWrite !== m_we) begin n_fail++; $display("FAIL rand_regWrite cycle %0d got %b want %b", i, regWrite, m_we); end
            if (errCnt !== 8'(m_err)) begin n_fail++; $display("FAIL rand_errCnt cycle %0d got %0d want %0d", i, errCnt, m_err); end
            if (m_we) begin
                n_checks += 2;
                if (writeRegister !== m_addr) begin n_fail++; $display("FAIL rand_writeRegister cycle %0d got %0d want %0d", i, writeRegister, m_addr); end
                if (writeData !== m_data) begin n_fail++; $display("FAIL rand_writeData cycle %0d got %h want %h", i, writeData, m_data); end
            end
            hold0 = req0Valid && w != 0;
            hold1 = req1Valid && w != 1;
            tick();
        end
        req0Valid = 0; req1Valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_squash();
        test_hazard();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
